// File: rtl/tx_iq_buffer_if.sv
// Host-write and transmitter read-strobe signals of the TX I/Q sample buffer.
// The slave modport is the buffer; the master modport is the host/transmitter side.
interface tx_iq_buffer_if;
  logic [15:0] host_data;
  logic        host_wr;
  logic        host_sync;
  logic        host_full;
  logic        tsiq_read_strobe;
  logic [31:0] tsiq_data;
  logic        tsiq_valid;

  modport master (
    output host_data, host_wr, host_sync, tsiq_read_strobe,
    input  host_full, tsiq_data, tsiq_valid
  );

  modport slave (
    input  host_data, host_wr, host_sync, tsiq_read_strobe,
    output host_full, tsiq_data, tsiq_valid
  );
endinterface

// File: rtl/tx_iq_buffer.sv
// Show-ahead TX I/Q buffer: pairs host halfwords into {I,Q} words, gates output
// until primed, and counts framing, overflow and underflow events.
module tx_iq_buffer #(
  parameter int AW          = 10,
  parameter int PRIME_LEVEL = 256,
  parameter int FULL_MARGIN = 16
) (
  input  logic          clk,
  input  logic          reset,
  tx_iq_buffer_if.slave bus,
  input  logic          flush,
  output logic [AW:0]   fill_level,
  output logic [15:0]   underflow_cnt,
  output logic [15:0]   overflow_cnt,
  output logic [15:0]   frame_err_cnt
);
  localparam int unsigned   DEPTH     = 2**AW;
  localparam logic [AW:0]   FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PRIME_LVL = (AW+1)'(PRIME_LEVEL);
  localparam logic [AW:0]   HFULL_LVL = (AW+1)'(DEPTH - FULL_MARGIN);
  localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic {PRIMING, RUN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          phase;
  logic [15:0]   i_hold;
  logic [31:0]   last_q, head;
  logic          latch_i, push_req, push_en, pop_en, full, valid;
  logic          ovf_inc, udf_inc, ferr_inc;
  logic [AW:0]   fill_nxt;

  assign head              = mem[rd_ptr];
  assign full              = (fill_level == FULL_LVL);
  assign valid             = (state == RUN) && (fill_level != '0);
  assign bus.tsiq_valid    = valid;
  // Head is read combinationally so the word is present with the strobe;
  // last_q keeps the output defined once the FIFO drains.
  assign bus.tsiq_data     = (fill_level != '0) ? head : last_q;
  assign bus.host_full     = (fill_level >= HFULL_LVL);

  always_comb begin
    latch_i   = bus.host_wr && (!phase || bus.host_sync);
    push_req  = bus.host_wr && phase && !bus.host_sync;
    ferr_inc  = bus.host_wr && phase && bus.host_sync && !flush;
    pop_en    = valid && bus.tsiq_read_strobe && !flush;
    udf_inc   = (state == RUN) && bus.tsiq_read_strobe && !valid && !flush;
    push_en   = push_req && (!full || pop_en) && !flush;
    ovf_inc   = push_req && full && !pop_en && !flush;

    fill_nxt = fill_level;
    if (flush)
      fill_nxt = '0;
    else if (push_en && !pop_en)
      fill_nxt = fill_level + FILL_ONE;
    else if (pop_en && !push_en)
      fill_nxt = fill_level - FILL_ONE;

    // Priming looks at the post-edge fill so valid rises right after the
    // edge that reaches PRIME_LEVEL.
    state_nxt = state;
    case (state)
      PRIMING: if (fill_nxt >= PRIME_LVL) state_nxt = RUN;
      RUN:     if (udf_inc)               state_nxt = PRIMING;
    endcase
    if (flush) state_nxt = PRIMING;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PRIMING;
      fill_level    <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      phase         <= 1'b0;
      i_hold        <= '0;
      last_q        <= '0;
      underflow_cnt <= '0;
      overflow_cnt  <= '0;
      frame_err_cnt <= '0;
    end else begin
      state      <= state_nxt;
      fill_level <= fill_nxt;
      if (fill_level != '0) last_q <= head;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        phase  <= 1'b0;
      end else begin
        if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
        if (latch_i) begin
          i_hold <= bus.host_data;
          phase  <= 1'b1;
        end else if (push_req) begin
          phase <= 1'b0;
        end
      end
      if (udf_inc  && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 16'd1;
      if (ovf_inc  && overflow_cnt  != '1) overflow_cnt  <= overflow_cnt  + 16'd1;
      if (ferr_inc && frame_err_cnt != '1) frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= {i_hold, bus.host_data};
  end
endmodule

// File: tb/tb_tx_iq_buffer.sv
// Bench for tx_iq_buffer: a default-size and a small instance, each checked
// every cycle against a queue-based reference model plus directed scenarios.
module tb_tx_iq_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, fl_b, rst_s, fl_s;
  logic [10:0] fill_b;
  logic [4:0]  fill_s;
  logic [15:0] udf_b, ovf_b, ferr_b, udf_s, ovf_s, ferr_s;

  tx_iq_buffer_if bif ();
  tx_iq_buffer_if sif ();

  tx_iq_buffer #(.AW(10), .PRIME_LEVEL(256), .FULL_MARGIN(16)) u_big (
    .clk(clk), .reset(rst_b), .bus(bif), .flush(fl_b), .fill_level(fill_b),
    .underflow_cnt(udf_b), .overflow_cnt(ovf_b), .frame_err_cnt(ferr_b));

  tx_iq_buffer #(.AW(4), .PRIME_LEVEL(16), .FULL_MARGIN(2)) u_sml (
    .clk(clk), .reset(rst_s), .bus(sif), .flush(fl_s), .fill_level(fill_s),
    .underflow_cnt(udf_s), .overflow_cnt(ovf_s), .frame_err_cnt(ferr_s));

  int checks = 0;
  int failures = 0;

  // reference model
  int          sel;
  int          m_depth, m_prime, m_fm;
  logic [31:0] mq[$];
  bit          m_run, m_phase, m_init;
  logic [15:0] m_i, m_udf, m_ovf, m_ferr;
  logic [31:0] m_last;

  logic        obs_valid, obs_full;
  logic [31:0] obs_data, obs_fill;
  logic [15:0] obs_udf, obs_ovf, obs_ferr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  task automatic sample();
    if (sel == 0) begin
      obs_valid = bif.tsiq_valid; obs_data = bif.tsiq_data; obs_full = bif.host_full;
      obs_fill = 32'(fill_b); obs_udf = udf_b; obs_ovf = ovf_b; obs_ferr = ferr_b;
    end else begin
      obs_valid = sif.tsiq_valid; obs_data = sif.tsiq_data; obs_full = sif.host_full;
      obs_fill = 32'(fill_s); obs_udf = udf_s; obs_ovf = ovf_s; obs_ferr = ferr_s;
    end
  endtask

  task automatic drive(input logic wr, input logic sync, input logic [15:0] d,
                       input logic stb, input logic fl, input logic rst);
    if (sel == 0) begin
      bif.host_wr = wr; bif.host_sync = sync; bif.host_data = d; bif.tsiq_read_strobe = stb;
      fl_b = fl; rst_b = rst;
      sif.host_wr = 1'b0; sif.host_sync = 1'b0; sif.host_data = '0; sif.tsiq_read_strobe = 1'b0;
      fl_s = 1'b0; rst_s = 1'b1;
    end else begin
      sif.host_wr = wr; sif.host_sync = sync; sif.host_data = d; sif.tsiq_read_strobe = stb;
      fl_s = fl; rst_s = rst;
      bif.host_wr = 1'b0; bif.host_sync = 1'b0; bif.host_data = '0; bif.tsiq_read_strobe = 1'b0;
      fl_b = 1'b0; rst_b = 1'b1;
    end
  endtask

  task automatic compare();
    logic [31:0] exp_data;
    if (!m_init) return;
    sample();
    exp_data = (mq.size() > 0) ? mq[0] : m_last;
    if (mq.size() > 0) m_last = mq[0];
    check_eq("tsiq_valid", 32'(obs_valid), 32'(m_run && (mq.size() > 0)));
    check_eq("tsiq_data", obs_data, exp_data);
    check_eq("host_full", 32'(obs_full), 32'(mq.size() >= m_depth - m_fm));
    check_eq("fill_level", obs_fill, 32'(mq.size()));
    check_eq("underflow_cnt", 32'(obs_udf), 32'(m_udf));
    check_eq("overflow_cnt", 32'(obs_ovf), 32'(m_ovf));
    check_eq("frame_err_cnt", 32'(obs_ferr), 32'(m_ferr));
  endtask

  task automatic model_update(input logic wr, input logic sync, input logic [15:0] d,
                              input logic stb, input logic fl, input logic rst);
    bit          vld, pop, udf, push;
    int          n0;
    logic [31:0] word;
    if (rst) begin
      mq.delete(); m_run = 0; m_phase = 0; m_i = '0;
      m_udf = '0; m_ovf = '0; m_ferr = '0; m_last = '0; m_init = 1;
      return;
    end
    if (fl) begin
      mq.delete(); m_run = 0; m_phase = 0;
      return;
    end
    vld  = m_run && (mq.size() > 0);
    pop  = vld && stb;
    udf  = m_run && stb && !vld;
    push = wr && m_phase && !sync;
    n0   = mq.size();
    word = {m_i, d};
    if (wr && m_phase && sync) m_ferr = sat(m_ferr);
    if (wr && (!m_phase || sync)) begin
      m_i = d; m_phase = 1;
    end else if (wr) begin
      m_phase = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (n0 == m_depth && !pop) m_ovf = sat(m_ovf);
      else mq.push_back(word);
    end
    if (udf) begin
      m_udf = sat(m_udf); m_run = 0;
    end else if (!m_run && mq.size() >= m_prime) begin
      m_run = 1;
    end
  endtask

  task automatic step(input logic wr, input logic sync, input logic [15:0] d,
                      input logic stb, input logic fl, input logic rst);
    drive(wr, sync, d, stb, fl, rst);
    #1;
    compare();
    @(posedge clk);
    model_update(wr, sync, d, stb, fl, rst);
    #1;
  endtask

  task automatic wr_pair(input logic [15:0] i_val, input logic [15:0] q_val);
    step(1'b1, 1'b1, i_val, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, q_val, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic strobe();
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rand_run(input int n, input int wr_pct, input int stb_pct, input int fl_pm);
    logic wr, sync, stb, fl;
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      wr   = ($urandom % 100) < wr_pct;
      sync = m_phase ? (($urandom % 100) < 8) : (($urandom % 100) < 90);
      d    = 16'($urandom);
      stb  = ($urandom % 100) < stb_pct;
      fl   = ($urandom % 1000) < fl_pm;
      step(wr, sync, d, stb, fl, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    sample();
    check_eq({pfx, "_valid"}, 32'(obs_valid), 32'd0);
    check_eq({pfx, "_data"}, obs_data, 32'd0);
    check_eq({pfx, "_full"}, 32'(obs_full), 32'd0);
    check_eq({pfx, "_fill"}, obs_fill, 32'd0);
    check_eq({pfx, "_udf"}, 32'(obs_udf), 32'd0);
    check_eq({pfx, "_ovf"}, 32'(obs_ovf), 32'd0);
    check_eq({pfx, "_ferr"}, 32'(obs_ferr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    m_init = 0;
    sel = 0; m_depth = 1024; m_prime = 256; m_fm = 16;
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check_reset_outputs("big_reset");

    // prime: 256 pairs I=k, Q=-k, no strobes
    for (int k = 0; k < 256; k++) begin
      wr_pair(16'(k), 16'(-k));
      if (k == 254) begin sample(); check_eq("prime_valid_pair255", 32'(obs_valid), 32'd0); end
      if (k == 255) begin
        sample();
        check_eq("prime_valid_pair256", 32'(obs_valid), 32'd1);
        check_eq("prime_first_word", obs_data, 32'd0);
      end
    end
    for (int k = 0; k < 255; k++) strobe();
    sample(); check_eq("prime_last_word", obs_data, 32'h00FF_FF01);
    strobe();

    // underflow: second extra strobe lands in PRIMING and is not counted
    strobe();
    sample();
    check_eq("udf_cnt_first", 32'(obs_udf), 32'd1);
    check_eq("udf_valid", 32'(obs_valid), 32'd0);
    strobe();
    sample(); check_eq("udf_cnt_second", 32'(obs_udf), 32'd1);

    // framing: orphaned I is replaced by the synced one
    step(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    sample();
    check_eq("frame_err_cnt", 32'(obs_ferr), 32'd1);
    check_eq("frame_word", obs_data, 32'h2222_3333);

    // flush with Q write at fill_level=100 in RUN; counters survive
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 256; k++) wr_pair(16'(k + 1000), 16'(k * 3));
    for (int k = 0; k < 156; k++) strobe();
    sample();
    check_eq("pre_flush_fill", obs_fill, 32'd100);
    check_eq("pre_flush_valid", 32'(obs_valid), 32'd1);
    step(1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1, 1'b0);
    sample();
    check_eq("flush_fill", obs_fill, 32'd0);
    check_eq("flush_valid", 32'(obs_valid), 32'd0);
    check_eq("flush_udf_kept", 32'(obs_udf), 32'd1);
    check_eq("flush_ferr_kept", 32'(obs_ferr), 32'd1);

    rand_run(1500, 90, 10, 1);
    rand_run(1500, 40, 60, 1);
    step(1'b1, 1'b0, 16'($urandom), 1'b1, 1'b0, 1'b1);
    check_reset_outputs("big_midreset");

    // small instance: AW=4, PRIME_LEVEL=16, FULL_MARGIN=2
    sel = 1; m_init = 0; m_depth = 16; m_prime = 16; m_fm = 2;
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check_reset_outputs("sml_reset");
    for (int k = 0; k < 18; k++) begin
      wr_pair(16'(k + 16'h10), 16'(k));
      if (k == 12) begin sample(); check_eq("full_at_13", 32'(obs_full), 32'd0); end
      if (k == 13) begin sample(); check_eq("full_at_14", 32'(obs_full), 32'd1); end
    end
    sample();
    check_eq("ovf_fill", obs_fill, 32'd16);
    check_eq("ovf_cnt", 32'(obs_ovf), 32'd2);

    // push and pop together while full
    step(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'hBBBB, 1'b1, 1'b0, 1'b0);
    sample();
    check_eq("pushpop_fill", obs_fill, 32'd16);
    check_eq("pushpop_ovf", 32'(obs_ovf), 32'd2);
    for (int k = 0; k < 15; k++) strobe();
    sample(); check_eq("pushpop_last_word", obs_data, 32'hAAAA_BBBB);
    strobe();
    sample(); check_eq("drained_fill", obs_fill, 32'd0);

    rand_run(3000, 60, 40, 2);
    step(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b0, 1'b1);
    check_reset_outputs("sml_midreset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
